// File: rtl/rsa_job_ctrl.sv
// Job sequencer between the SPI register bank and rsa_unit.
// Optional RUN watchdog: define RSA_CTRL_TIMEOUT_EN.
module rsa_job_ctrl #(
    parameter int W           = 8,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 60000,
    parameter int GAP_CYC     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             clr_i,
    input  logic [W-1:0]     p_i,
    input  logic [W-1:0]     e_i,
    input  logic [W-1:0]     m_i,
    input  logic [W-1:0]     const_i,
    output logic             rsa_en_o,
    output logic             rsa_rstb_o,
    output logic [W-1:0]     rsa_p_o,
    output logic [W-1:0]     rsa_e_o,
    output logic [W-1:0]     rsa_m_o,
    output logic [W-1:0]     rsa_const_o,
    input  logic             rsa_eoc_i,
    input  logic [W-1:0]     rsa_c_i,
    output logic [W-1:0]     result_o,
    output logic             result_vld_o,
    output logic [7:0]       status_o,
    output logic [CNT_W-1:0] cycles_o
);

`ifdef RSA_CTRL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE,
        S_ABORT,
        S_GAP
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             busy;
    logic             armed;
    logic             accept;
    logic             take;
    logic             tmo_hit;
    logic             gap_last;
    logic             done_st;
    logic             tmo_st;
    logic             ovr_st;
    logic             abt_st;
    logic [CNT_W-1:0] cyc_inc;
    logic [GAP_W-1:0] gap_cnt;

    assign cyc_inc  = (&cycles_o) ? cycles_o : cycles_o + 1'b1;
    assign accept   = (state == S_RUN) && armed && rsa_eoc_i;
    assign take     = accept && !abort_i;
    assign gap_last = (gap_cnt == GAP_W'(GAP_CYC - 1));

    // Watchdog fires on the cycle the count would reach the limit.
    assign tmo_hit = TMO_EN && (state == S_RUN) && !accept &&
                     (cyc_inc == CNT_W'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start_i) state_nx = S_LOAD;
            S_LOAD:  state_nx = S_RUN;
            S_RUN: begin
                if (abort_i || tmo_hit) begin
                    state_nx = S_ABORT;
                end else if (accept) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_GAP;
            S_ABORT: state_nx = S_GAP;
            S_GAP:   if (gap_last) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        rsa_en_o   = (state == S_RUN);
        rsa_rstb_o = (state != S_ABORT);
        busy       = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsa_p_o      <= '0;
            rsa_e_o      <= '0;
            rsa_m_o      <= '0;
            rsa_const_o  <= '0;
            result_o     <= '0;
            result_vld_o <= 1'b0;
            cycles_o     <= '0;
            armed        <= 1'b0;
            gap_cnt      <= '0;
        end else begin
            result_vld_o <= take;
            if (take) begin
                result_o <= rsa_c_i;
            end
            if (state == S_LOAD) begin
                rsa_p_o     <= p_i;
                rsa_e_o     <= e_i;
                rsa_m_o     <= m_i;
                rsa_const_o <= const_i;
                cycles_o    <= '0;
                armed       <= 1'b0;
            end
            // A level eoc left over from the previous job is not trusted
            // until the unit has been seen low at least once.
            if (state == S_RUN) begin
                cycles_o <= cyc_inc;
                if (!rsa_eoc_i) begin
                    armed <= 1'b1;
                end
            end
            if (state == S_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_st <= 1'b0;
            tmo_st  <= 1'b0;
            ovr_st  <= 1'b0;
            abt_st  <= 1'b0;
        end else begin
            done_st <= (state == S_DONE) || (done_st && !clr_i);
            tmo_st  <= tmo_hit || (tmo_st && !clr_i);
            ovr_st  <= (start_i && busy) || (ovr_st && !clr_i);
            abt_st  <= (state == S_ABORT) || (abt_st && !clr_i);
        end
    end

    assign status_o = {3'b000, abt_st, ovr_st, tmo_st, busy, done_st};

endmodule

// File: tb/tb_rsa_job_ctrl.sv
// Bench for rsa_job_ctrl: rsa_unit stub, directed job table and
// randomized jobs checked against a job-level reference model.
module tb_rsa_job_ctrl;
    localparam int TMO = 50;
`ifdef RSA_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0]  p, e, m, c;
        int          n, abort_at, ovr_at, stale;
        bit          abort_start, clr;
        logic [7:0]  exp_result;
        logic [15:0] exp_cycles;
        logic [7:0]  exp_status;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_i = 1'b0, abort_i = 1'b0, clr_i = 1'b0;
    logic [7:0] p_i = '0, e_i = '0, m_i = '0, const_i = '0;
    logic rsa_en_o, rsa_rstb_o, rsa_eoc_i, result_vld_o;
    logic [7:0] rsa_p_o, rsa_e_o, rsa_m_o, rsa_const_o;
    logic [7:0] rsa_c_i, result_o, status_o;
    logic [15:0] cycles_o;

    int stub_n = 20, stub_stale = 0, stub_cnt = 0;
    bit stale_hi = 1'b0;
    logic [7:0] stub_c = '0;

    int errors = 0, checks = 0;
    logic [7:0] mres = '0, mst = '0;
    vec_t tbl[5];
    vec_t rv;

    rsa_job_ctrl #(.W(8), .CNT_W(16), .TIMEOUT_CYC(TMO), .GAP_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .clr_i(clr_i), .p_i(p_i), .e_i(e_i), .m_i(m_i), .const_i(const_i),
        .rsa_en_o(rsa_en_o), .rsa_rstb_o(rsa_rstb_o), .rsa_p_o(rsa_p_o),
        .rsa_e_o(rsa_e_o), .rsa_m_o(rsa_m_o), .rsa_const_o(rsa_const_o),
        .rsa_eoc_i(rsa_eoc_i), .rsa_c_i(rsa_c_i), .result_o(result_o),
        .result_vld_o(result_vld_o), .status_o(status_o), .cycles_o(cycles_o)
    );

    always #5 clk = ~clk;

    // rsa_unit stub: eoc N cycles after en rises, optional stale eoc at launch
    always @(posedge clk) stub_cnt <= rsa_en_o ? stub_cnt + 1 : 0;
    assign rsa_eoc_i = rsa_en_o ? (stub_cnt < stub_stale || stub_cnt >= stub_n)
                                : stale_hi;
    assign rsa_c_i = stub_c;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void job_stop(input vec_t v, output int stop,
                                     output bit ab, output bit tmo);
        stop = v.n;
        ab = 1'b0;
        tmo = 1'b0;
        if (v.abort_at >= 0 && v.abort_at <= v.n) begin
            stop = v.abort_at;
            ab = 1'b1;
        end
        if (TO_EN && TMO - 1 < stop) begin
            stop = TMO - 1;
            ab = 1'b1;
            tmo = 1'b1;
        end
    endfunction

    task automatic run_vec(input vec_t v);
        int stop, k, vld, vld_k, rlo, bad;
        bit ab, tmo, ovr;
        job_stop(v, stop, ab, tmo);
        ovr = (v.ovr_at >= 0) && (v.ovr_at < stop + 4);
        p_i = v.p; e_i = v.e; m_i = v.m; const_i = v.c;
        stub_n = v.n; stub_stale = v.stale; stub_c = v.c;
        stale_hi = (v.stale > 0);
        start_i = 1'b1;
        abort_i = v.abort_start;
        @(negedge clk);
        start_i = 1'b0;
        chk("load_state", {rsa_en_o, status_o[1]}, 2'b01);
        @(negedge clk);
        abort_i = 1'b0;
        stale_hi = 1'b0;
        chk("run_en", rsa_en_o, 1);
        k = 0; vld = 0; vld_k = -1; rlo = 0; bad = 0;
        while (status_o[1] && k < 3000) begin
            abort_i = (k == v.abort_at);
            start_i = (k == v.ovr_at);
            p_i = 8'($urandom); e_i = 8'($urandom);
            m_i = (k == v.ovr_at) ? 8'd9 : 8'($urandom);
            const_i = 8'($urandom);
            @(negedge clk);
            k++;
            abort_i = 1'b0;
            start_i = 1'b0;
            if (result_vld_o) begin vld++; vld_k = k; end
            if (!rsa_rstb_o) rlo++;
            if (rsa_en_o !== (k <= stop)) bad++;
            if ({rsa_p_o, rsa_e_o, rsa_m_o, rsa_const_o} !==
                {v.p, v.e, v.m, v.c}) bad++;
        end
        chk("busy_len", k, stop + 4);
        chk("vld_pulse", ab ? vld : vld_k, ab ? 0 : stop + 1);
        if (!ab) chk("vld_count", vld, 1);
        chk("rstb_low", rlo, ab ? 1 : 0);
        chk("en_ops", bad, 0);
        chk("result", result_o, v.exp_result);
        chk("cycles", cycles_o, v.exp_cycles);
        chk("status", status_o, v.exp_status);
        if (!ab) mres = v.c;
        mst = mst | (ab ? 8'h10 : 8'h01) | (tmo ? 8'h04 : 8'h00)
                  | (ovr ? 8'h08 : 8'h00);
        if (v.clr) begin
            clr_i = 1'b1;
            @(negedge clk);
            clr_i = 1'b0;
            mst = '0;
            chk("clr", status_o, 8'h00);
        end
    endtask

    initial begin
        int stop;
        bit ab, tmo;
        tbl[0] = '{8'd33, 8'd7, 8'd4, 8'h10, 20, -1, -1, 0, 1'b0, 1'b0,
                   8'h10, 16'd21, 8'h01};
        tbl[1] = '{8'd33, 8'd7, 8'd4, 8'h22, 20, -1, 5, 0, 1'b1, 1'b1,
                   8'h22, 16'd21, 8'h09};
        tbl[2] = '{8'd5, 8'd3, 8'd7, 8'h55, 100, 10, -1, 0, 1'b0, 1'b0,
                   8'h22, 16'd11, 8'h10};
        tbl[3] = '{8'd1, 8'd2, 8'd3, 8'h77, 15, -1, -1, 3, 1'b0, 1'b1,
                   8'h77, 16'd16, 8'h11};
`ifdef RSA_CTRL_TIMEOUT_EN
        tbl[4] = '{8'd9, 8'd9, 8'd9, 8'h99, 100000, 1000, -1, 0, 1'b0, 1'b1,
                   8'h77, 16'd50, 8'h14};
`else
        tbl[4] = '{8'd9, 8'd9, 8'd9, 8'h99, 100000, 1000, -1, 0, 1'b0, 1'b1,
                   8'h77, 16'd1001, 8'h10};
`endif

        repeat (3) @(negedge clk);
        chk("rst_ctl", {rsa_en_o, rsa_rstb_o, result_vld_o, status_o, cycles_o},
            {1'b0, 1'b1, 1'b0, 8'h00, 16'h0000});
        chk("rst_data", {result_o, rsa_p_o, rsa_e_o, rsa_m_o, rsa_const_o}, 40'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(tbl[i]);

        // reset in the middle of a running job
        p_i = 8'hA5; e_i = 8'h5A; m_i = 8'h3C; const_i = 8'hC3;
        stub_n = 20; stub_stale = 0; stub_c = 8'h66;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ctl", {rsa_en_o, rsa_rstb_o, result_vld_o, status_o, cycles_o},
            {1'b0, 1'b1, 1'b0, 8'h00, 16'h0000});
        chk("midrst_data", {result_o, rsa_p_o, rsa_e_o, rsa_m_o, rsa_const_o},
            40'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mres = '0;
        mst = '0;
        @(negedge clk);
        run_vec(tbl[0]);

        for (int j = 0; j < 40; j++) begin
            rv.p = 8'($urandom); rv.e = 8'($urandom);
            rv.m = 8'($urandom); rv.c = 8'($urandom);
            rv.n = $urandom_range(30, 1);
            rv.stale = (rv.n >= 2 && $urandom_range(3, 0) == 0)
                       ? $urandom_range(rv.n - 1, 1) : 0;
            rv.abort_at = ($urandom_range(9, 0) < 3) ? $urandom_range(35, 0) : -1;
            rv.ovr_at = ($urandom_range(9, 0) < 3) ? $urandom_range(40, 0) : -1;
            rv.abort_start = ($urandom_range(4, 0) == 0);
            rv.clr = ($urandom_range(9, 0) < 3);
            job_stop(rv, stop, ab, tmo);
            rv.exp_result = ab ? mres : rv.c;
            rv.exp_cycles = 16'(stop + 1);
            rv.exp_status = mst | (ab ? 8'h10 : 8'h01) | (tmo ? 8'h04 : 8'h00)
                | ((rv.ovr_at >= 0 && rv.ovr_at < stop + 4) ? 8'h08 : 8'h00);
            run_vec(rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
